// File: rtl/mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | mem_access_unit: byte/half/word load-store engine over a 32-bit SRAM,    |
// | read-modify-write for sub-word stores. Option macro: MAU_ALIGN_CHECK_EN. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] sram_addr,
  output logic [31:0] w_sram,
  output logic        w_sram_en,
  input  logic [31:0] r_sram
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        fault_req;
  logic [31:0] lane_word;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

`ifdef MAU_ALIGN_CHECK_EN
  assign fault_req = (req_size == SZ_RSVD)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign fault_req = (req_size == SZ_RSVD);
`endif

  // Lane extraction: byte lane shifted down, halfword picked by addr[1].
  assign lane_word = r_sram >> {addr_q[1:0], 3'b000};
  assign lane_half = addr_q[1] ? r_sram[31:16] : r_sram[15:0];

  always_comb begin
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & lane_word[7]}}, lane_word[7:0]};
      SZ_HALF: load_ext = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_ext = r_sram;
    endcase
  end

  always_comb begin
    merged = r_sram;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (fault_req) begin
            rdata_d = 32'h0;
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (write_q && (size_q != SZ_WORD)) begin
          merge_d = merged;
          state_d = WRITE;
        end else begin
          rdata_d = write_q ? 32'h0 : load_ext;
          fault_d = 1'b0;
          state_d = RESP;
        end
      end
      WRITE: begin
        rdata_d = 32'h0;
        fault_d = 1'b0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // Memory-side outputs are decoded from state so an async reset drops them at once.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign sram_addr  = ((state_q == ACCESS) || (state_q == WRITE)) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign w_sram_en  = ((state_q == ACCESS) && write_q && (size_q == SZ_WORD)) || (state_q == WRITE);
  assign w_sram     = (state_q == WRITE) ? merge_q :
                      (w_sram_en ? wdata_q : 32'h0);

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | tb_mem_access_unit: directed table, corner sequences and random traffic  |
// | against a byte-array memory model. Honours MAU_ALIGN_CHECK_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

`ifdef MAU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] sram_addr;
  logic [31:0] w_sram;
  logic        w_sram_en;
  logic [31:0] r_sram;

  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:255];
  logic        tb_wr_en = 1'b0;
  logic [5:0]  tb_wr_idx = 6'd0;
  logic [31:0] tb_wr_data = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .sram_addr(sram_addr), .w_sram(w_sram),
    .w_sram_en(w_sram_en), .r_sram(r_sram)
  );

  assign r_sram = mem[sram_addr[7:2]];

  always @(posedge clk) begin
    if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_data;
    else if (w_sram_en) mem[sram_addr[7:2]] <= w_sram;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Preloads one memory word and mirrors it into the byte model.
  task automatic tb_write(input int idx, input logic [31:0] data);
    tb_wr_en = 1'b1;
    tb_wr_idx = idx[5:0];
    tb_wr_data = data;
    for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = data[8*k +: 8];
    @(posedge clk);
    #1 tb_wr_en = 1'b0;
  endtask

  function automatic logic [31:0] ref_word(input int b);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // Reference model: predicts the response and applies the store to the byte array.
  task automatic model_step(input bit wr, input logic [1:0] sz, input bit sg,
                            input logic [31:0] ad, input logic [31:0] wd,
                            output logic [31:0] rd, output bit f, output int lat,
                            output logic [31:0] ww);
    int a;
    int h;
    int b;
    logic [15:0] hv;
    logic [31:0] v;
    a = int'(ad[7:0]);
    h = a - (a % 2);
    b = a - (a % 4);
    f = (sz == 2'b11) || (ALIGN_CHK && (((sz == 2'b01) && (a % 2 != 0)) ||
                                        ((sz == 2'b10) && (a % 4 != 0))));
    lat = f ? 1 : ((wr && sz != 2'b10) ? 3 : 2);
    ww = 32'h0;
    hv = {ref_mem[h+1], ref_mem[h]};
    case (sz)
      2'b00:   v = sg ? {{24{ref_mem[a][7]}}, ref_mem[a]} : {24'h0, ref_mem[a]};
      2'b01:   v = sg ? {{16{hv[15]}}, hv} : {16'h0, hv};
      default: v = ref_word(b);
    endcase
    rd = (f || wr) ? 32'h0 : v;
    if (wr && !f) begin
      case (sz)
        2'b00: ref_mem[a] = wd[7:0];
        2'b01: begin ref_mem[h] = wd[7:0]; ref_mem[h+1] = wd[15:8]; end
        default: for (int k = 0; k < 4; k++) ref_mem[b+k] = wd[8*k +: 8];
      endcase
      ww = ref_word(b);
    end
  endtask

  task automatic run_req(input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input bit use_tbl, input logic [31:0] t_rd, input bit t_f,
                         input int t_lat, input logic [31:0] t_ww, input string nm);
    logic [31:0] e_rd, e_ww, got_rd, got_ww, got_wa, al;
    bit e_f, got_f;
    int e_lat, lat, nwr, wcyc;
    model_step(wr, sz, sg, ad, wd, e_rd, e_f, e_lat, e_ww);
    if (use_tbl) begin
      e_rd = t_rd; e_f = t_f; e_lat = t_lat; e_ww = t_ww;
    end
    al = {ad[31:2], 2'b00};
    lat = 0; nwr = 0; wcyc = 0; got_rd = 32'h0; got_ww = 32'h0; got_wa = 32'h0; got_f = 1'b0;
    for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
    chk({nm, " ready"}, {31'h0, req_ready}, 32'h1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) chk({nm, " sram_addr"}, sram_addr, e_f ? 32'h0 : al);
      if (w_sram_en) begin
        nwr++; wcyc = c; got_ww = w_sram; got_wa = sram_addr;
      end
      if (resp_valid) begin
        lat = c; got_rd = resp_rdata; got_f = resp_fault;
        chk({nm, " idle_addr"}, sram_addr, 32'h0);
        break;
      end
    end
    chk({nm, " latency"}, lat, e_lat);
    chk({nm, " rdata"}, got_rd, e_rd);
    chk({nm, " fault"}, {31'h0, got_f}, {31'h0, e_f});
    chk({nm, " writes"}, nwr, (wr && !e_f) ? 1 : 0);
    if (wr && !e_f) begin
      chk({nm, " wdata"}, got_ww, e_ww);
      chk({nm, " waddr"}, got_wa, al);
      chk({nm, " wcycle"}, wcyc, (sz == 2'b10) ? 1 : 2);
      chk({nm, " memword"}, mem[al[7:2]], ref_word(int'(al[7:0])));
    end
    @(negedge clk);
    chk({nm, " hold"}, resp_rdata, e_rd);
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          f;
    int          lat;
    logic [31:0] ww;
  } vec_t;

  vec_t tbl [15];
  logic [31:0] d_rd, d_ww;
  bit d_f;
  int d_lat;
  logic [5:0] rdy_v, rsp_v, wen_v;
  int n_resp;

  initial begin
    tbl[0]  = '{1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 32'hFFFFFFE1, 1'b0, 2, 32'h0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 32'h000000E1, 1'b0, 2, 32'h0};
    tbl[2]  = '{1'b0, 2'b01, 1'b1, 32'h04, 32'h0, 32'h00001332, 1'b0, 2, 32'h0};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 32'hFFFFE1A0, 1'b0, 2, 32'h0};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'h00000013, 1'b0, 2, 32'h0};
    tbl[5]  = ALIGN_CHK ? '{1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 32'h0}
                        : '{1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h11223344, 1'b0, 2, 32'h0};
    tbl[6]  = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 32'h0};
    tbl[7]  = ALIGN_CHK ? '{1'b0, 2'b01, 1'b0, 32'h07, 32'h0, 32'h0, 1'b1, 1, 32'h0}
                        : '{1'b0, 2'b01, 1'b0, 32'h07, 32'h0, 32'h0000E1A0, 1'b0, 2, 32'h0};
    tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0, 3, 32'hBEEF3344};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF3344, 1'b0, 2, 32'h0};
    tbl[10] = '{1'b1, 2'b00, 1'b1, 32'h05, 32'hFFFFFFAB, 32'h0, 1'b0, 3, 32'hE1A0AB32};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hE1A0AB32, 1'b0, 2, 32'h0};
    tbl[12] = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFEF00D, 32'h0, 1'b0, 2, 32'hCAFEF00D};
    tbl[13] = '{1'b1, 2'b11, 1'b0, 32'h08, 32'h12345678, 32'h0, 1'b1, 1, 32'h0};
    tbl[14] = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hCAFEF00D, 1'b0, 2, 32'h0};

    // Memory preload happens while the DUT is held in reset.
    for (int i = 0; i < 64; i++) begin
      tb_write(i, (i == 1) ? 32'hE1A01332 : (i == 4) ? 32'h11223344 : (i * 32'h9E3779B1));
    end
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_fault", {31'h0, resp_fault}, 32'h0);
    chk("rst_wen", {31'h0, w_sram_en}, 32'h0);
    chk("rst_wsram", w_sram, 32'h0);
    chk("rst_addr", sram_addr, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("post_rst_resp", {31'h0, resp_valid}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      run_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].ad, tbl[i].wd, 1'b1,
              tbl[i].rd, tbl[i].f, tbl[i].lat, tbl[i].ww, $sformatf("vec%0d", i));
    end

    // Two back-to-back word stores with req_valid held high throughout.
    rdy_v = '0; rsp_v = '0; wen_v = '0;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hA5A5_0001;
    model_step(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_0001, d_rd, d_f, d_lat, d_ww);
    req_valid = 1'b1;
    rdy_v[0] = req_ready; rsp_v[0] = resp_valid; wen_v[0] = w_sram_en;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rdy_v[c] = req_ready; rsp_v[c] = resp_valid; wen_v[c] = w_sram_en;
      if (c == 2) begin
        req_addr = 32'h24; req_wdata = 32'h5A5A_0002;
        model_step(1'b1, 2'b10, 1'b0, 32'h24, 32'h5A5A_0002, d_rd, d_f, d_lat, d_ww);
      end
      if (c == 4) req_valid = 1'b0;
    end
    chk("b2b_ready", {26'h0, rdy_v}, 32'b001001);
    chk("b2b_resp", {26'h0, rsp_v}, 32'b100100);
    chk("b2b_wen", {26'h0, wen_v}, 32'b010010);
    chk("b2b_mem0", mem[8], 32'hA5A5_0001);
    chk("b2b_mem1", mem[9], 32'h5A5A_0002);

    for (int i = 0; i < 150; i++) begin
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255)), $urandom, 1'b0, 32'h0, 1'b0, 0, 32'h0,
              $sformatf("rnd%0d", i));
    end

    // Reset lands while a byte store sits in WRITE.
    tb_write(4, 32'h11223344);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_write", {31'h0, w_sram_en}, 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_wen", {31'h0, w_sram_en}, 32'h0);
    chk("abort_wsram", w_sram, 32'h0);
    chk("abort_addr", sram_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    n_resp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    chk("abort_no_resp", n_resp, 0);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_mem", mem[4], 32'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
